// File: rtl/ice_arb_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbiter:
// FSM state encoding, mode constants and a width helper.
package ice_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: lowest eligible index (fixed) or first
// eligible index strictly above last_idx, wrapping (round-robin).
module arb_pick
    import ice_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] eligible,
    input  logic [IDXW-1:0]  last_idx,
    input  logic             rr_mode,
    output logic [WIDTH-1:0] winner,
    output logic [IDXW-1:0]  winner_idx,
    output logic             valid
);

    logic            any_valid;
    logic [IDXW-1:0] any_idx;
    logic            up_valid;
    logic [IDXW-1:0] up_idx;

    // Scanning downward leaves the lowest match in each category; when nothing
    // sits above last_idx, the lowest overall wraps around to last_idx last.
    always_comb begin
        any_valid = 1'b0;
        any_idx   = '0;
        up_valid  = 1'b0;
        up_idx    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any_valid = 1'b1;
                any_idx   = IDXW'(i);
                if (i > int'(last_idx)) begin
                    up_valid = 1'b1;
                    up_idx   = IDXW'(i);
                end
            end
        end
    end

    assign valid      = any_valid;
    assign winner_idx = ((rr_mode == MODE_RR) && up_valid) ? up_idx : any_idx;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign winner[gi] = any_valid && (winner_idx == IDXW'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_priority_arbiter.sv
// Single-grant arbiter with fixed or round-robin priority, per-requester
// masking, release handshake and optional hold-time limit.
module rr_priority_arbiter
    import ice_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          latch,
    input  logic                          rr_mode,
    input  logic [WIDTH-1:0]              mask,
    input  logic [WIDTH-1:0]              requests,
    // 'release' is a reserved word, hence release_req.
    input  logic                          release_req,
    output logic [WIDTH-1:0]              grants,
    output logic [idx_width(WIDTH)-1:0]   grant_idx,
    output logic                          granted,
    output logic                          timeout
);

    localparam int IDXW  = idx_width(WIDTH);
    localparam int CNT_W = idx_width(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(MAX_HOLD);
    localparam logic [IDXW-1:0]  LAST_INIT = IDXW'(WIDTH - 1);

    arb_state_t       state_reg, state_next;
    logic [WIDTH-1:0] grants_reg, grants_next;
    logic [IDXW-1:0]  grant_idx_reg, grant_idx_next;
    logic [IDXW-1:0]  last_idx_reg, last_idx_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             timeout_reg, timeout_next;

    logic [WIDTH-1:0] eligible;
    logic [WIDTH-1:0] pick_onehot;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_valid;
    logic             held_req;
    logic [CNT_W-1:0] cnt_inc;
    logic             hold_limit;
    logic             other_exit;
    logic             hold_exit;
    logic             start_hold;

    assign eligible = requests & ~mask;

    arb_pick #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_pick (
        .eligible   (eligible),
        .last_idx   (last_idx_reg),
        .rr_mode    (rr_mode),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    assign held_req   = |(grants_reg & requests);
    assign cnt_inc    = hold_cnt_reg + CNT_W'(1);
    // The current HOLD cycle is the MAX_HOLD-th one when the count would reach the limit.
    assign hold_limit = (MAX_HOLD != 0) && (cnt_inc == HOLD_LIM);
    assign other_exit = release_req || !held_req || !enable;
    assign hold_exit  = other_exit || hold_limit;
    assign start_hold = enable && latch && pick_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_hold) state_next = HOLD;
            HOLD:    if (hold_exit)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grants_next    = grants_reg;
        grant_idx_next = grant_idx_reg;
        last_idx_next  = last_idx_reg;
        hold_cnt_next  = hold_cnt_reg;
        timeout_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                grants_next    = '0;
                grant_idx_next = '0;
                hold_cnt_next  = '0;
                if (start_hold) begin
                    grants_next    = pick_onehot;
                    grant_idx_next = pick_idx;
                end
            end
            HOLD: begin
                if (hold_exit) begin
                    grants_next    = '0;
                    grant_idx_next = '0;
                    hold_cnt_next  = '0;
                    last_idx_next  = grant_idx_reg;
                    timeout_next   = hold_limit && !other_exit;
                end else if (hold_cnt_reg != HOLD_LIM) begin
                    hold_cnt_next = cnt_inc;
                end
            end
            default: begin
                grants_next    = '0;
                grant_idx_next = '0;
                hold_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grants_reg    <= '0;
            grant_idx_reg <= '0;
            last_idx_reg  <= LAST_INIT;
            hold_cnt_reg  <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            grants_reg    <= grants_next;
            grant_idx_reg <= grant_idx_next;
            last_idx_reg  <= last_idx_next;
            hold_cnt_reg  <= hold_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign grants    = grants_reg;
    assign grant_idx = grant_idx_reg;
    assign granted   = held_req;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's
// registered outputs; a separate monitor pops and compares them.
module tb_rr_priority_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         latch;
    logic         rr_mode;
    logic [W-1:0] mask;
    logic [W-1:0] requests;
    logic         release_req;
    logic [W-1:0] grants;
    logic [2:0]   grant_idx;
    logic         granted;
    logic         timeout;

    rr_priority_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .latch       (latch),
        .rr_mode     (rr_mode),
        .mask        (mask),
        .requests    (requests),
        .release_req (release_req),
        .grants      (grants),
        .grant_idx   (grant_idx),
        .granted     (granted),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] grants;
        logic [2:0]   idx;
        logic         tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Reference model: who holds the grant, for how many cycles, and who held last.
    bit m_hold = 1'b0;
    int m_held = 0;
    int m_cycles = 0;
    int m_last = W - 1;
    bit m_tmo = 1'b0;

    function automatic int ref_pick(input logic [W-1:0] elig, input bit rr, input int last);
        if (!rr) begin
            for (int i = 0; i < W; i++)
                if (((elig >> i) & 1) != 0) return i;
        end else begin
            for (int k = 1; k <= W; k++) begin
                int p;
                p = (last + k) % W;
                if (((elig >> p) & 1) != 0) return p;
            end
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, expv, n_txn);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l, input bit m,
                        input logic [W-1:0] mk, input logic [W-1:0] rq, input bit rl);
        exp_t x;
        int   w;
        bit   lim;
        bit   oth;
        @(posedge clk);
        #1;
        rst = r; enable = e; latch = l; rr_mode = m;
        mask = mk; requests = rq; release_req = rl;
        if (r) begin
            m_hold = 1'b0; m_held = 0; m_cycles = 0; m_last = W - 1; m_tmo = 1'b0;
        end else if (!m_hold) begin
            m_tmo = 1'b0;
            if (e && l) begin
                w = ref_pick(rq & ~mk, m, m_last);
                if (w >= 0) begin
                    m_hold = 1'b1; m_held = w; m_cycles = 0;
                end
            end
        end else begin
            m_cycles++;
            lim = (MH > 0) && (m_cycles >= MH);
            oth = rl || (((rq >> m_held) & 1) == 0) || !e;
            if (lim || oth) begin
                m_tmo  = lim && !oth;
                m_last = m_held;
                m_hold = 1'b0;
            end else begin
                m_tmo = 1'b0;
            end
        end
        x.grants = m_hold ? W'(1 << m_held) : '0;
        x.idx    = m_hold ? 3'(m_held) : 3'd0;
        x.tmo    = m_tmo;
        exp_q.push_back(x);
    endtask

    // Monitor: every posedge with a pending expectation, compare shortly after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                #2;
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d grants=%h idx=%0d granted=%b timeout=%b", n_txn, grants, grant_idx, granted, timeout);
                check("grants", 32'(grants), 32'(e.grants));
                check("grant_idx", 32'(grant_idx), 32'(e.idx));
                check("timeout", 32'(timeout), 32'(e.tmo));
                check("granted", 32'(granted), 32'(|(e.grants & requests)));
            end
        end
    end

    initial begin
        logic [W-1:0] rq;
        bit           md;
        rst = 1'b1; enable = 1'b0; latch = 1'b0; rr_mode = 1'b0;
        mask = '0; requests = '0; release_req = 1'b0;

        repeat (3) step(1, 0, 0, 0, 8'h00, 8'h00, 0);

        // Fixed priority: 0x28 -> index 3.
        step(0, 1, 1, 0, 8'h00, 8'h28, 0);
        step(0, 1, 0, 0, 8'h00, 8'h28, 0);
        step(0, 1, 0, 0, 8'h00, 8'h28, 1);
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);

        // Round-robin rotation from reset: 0..7,0.
        repeat (2) step(1, 0, 0, 1, 8'h00, 8'h00, 0);
        repeat (9) begin
            step(0, 1, 1, 1, 8'h00, 8'hFF, 0);
            step(0, 1, 0, 1, 8'h00, 8'hFF, 1);
        end

        // Mask changes during HOLD do not disturb the grant.
        step(0, 1, 1, 0, 8'h01, 8'h03, 0);
        step(0, 1, 0, 0, 8'h02, 8'h03, 0);
        step(0, 1, 0, 1, 8'h02, 8'h03, 0);
        step(0, 1, 0, 0, 8'h02, 8'h03, 1);
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);

        // Hold limit: timeout pulse, then release on the limit cycle.
        step(0, 1, 1, 0, 8'h00, 8'h04, 0);
        repeat (6) step(0, 1, 0, 0, 8'h00, 8'h04, 0);
        step(0, 1, 1, 0, 8'h00, 8'h04, 0);
        repeat (3) step(0, 1, 0, 0, 8'h00, 8'h04, 0);
        step(0, 1, 0, 0, 8'h00, 8'h04, 1);
        repeat (2) step(0, 1, 0, 0, 8'h00, 8'h04, 0);

        // Reset during HOLD, then first round-robin pick restarts at 0.
        repeat (2) step(1, 0, 0, 1, 8'h00, 8'h00, 0);
        step(0, 1, 1, 1, 8'h00, 8'h10, 0);
        step(0, 1, 0, 1, 8'h00, 8'h10, 0);
        step(1, 1, 0, 1, 8'h00, 8'h10, 0);
        step(0, 1, 1, 1, 8'h00, 8'h81, 0);
        step(0, 1, 0, 1, 8'h00, 8'h81, 0);
        step(0, 1, 0, 1, 8'h00, 8'h81, 1);

        // Randomized traffic with slowly varying requests.
        rq = W'($urandom);
        md = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 4) == 0) rq = W'($urandom);
            if ($urandom_range(0, 9) == 0) md = ~md;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 1) == 1, md,
                 W'($urandom) & W'($urandom), rq,
                 $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
